// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_INT = 2'b10;
    localparam logic [1:0] PC_SEL_TGT = 2'b11;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    localparam int IMEM_BOOT_ADDR = 0;
    localparam int IMEM_INT_ADDR  = 2;

    typedef enum logic [2:0] {
        BOOT_HI,
        BOOT_LO,
        RUN,
        VEC_HI,
        VEC_LO
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats freeze, freeze beats bubble, bubble beats load.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               freeze,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [PC_W-1:0]    fetch_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_reg;
    logic [PC_W-1:0]    pc_reg;
    logic               valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg <= INSTR_W'(NOP_INSTR);
            pc_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            // ifid_pc is deliberately left alone on a squash
            instr_reg <= INSTR_W'(NOP_INSTR);
            valid_reg <= 1'b0;
        end else if (freeze) begin
            instr_reg <= instr_reg;
        end else if (bubble) begin
            instr_reg <= INSTR_W'(NOP_INSTR);
            valid_reg <= 1'b0;
        end else begin
            instr_reg <= fetch_instr;
            pc_reg    <= fetch_pc;
            valid_reg <= 1'b1;
        end
    end

    assign instr = instr_reg;
    assign pc    = pc_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, boot vector load, split return-PC rebuild, IF/ID register.
// Define FETCH_INT_VECTOR_FROM_MEM_EN to fetch the interrupt vector from imem[2..3].
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter int              INSTR_W    = 16,
    parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0002
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic [1:0]         pc_sel,
    input  logic [PC_W-1:0]    target_in,
    input  logic               fetch_pc_enable,
    input  logic               freeze_cu,
    input  logic               flush_fetch,
    input  logic               pop_pc1,
    input  logic               pop_pc2,
    input  logic [INSTR_W-1:0] stack_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               boot_busy
);

    fetch_state_t       state_reg,  state_next;
    logic [PC_W-1:0]    pc_reg,     pc_next;
    logic [INSTR_W-1:0] vec_hi_reg, vec_hi_next;
    logic [INSTR_W-1:0] ret_hi_reg, ret_hi_next;
    logic [INSTR_W-1:0] ret_lo_reg, ret_lo_next;
    logic               got_hi_reg, got_hi_next;
    logic               got_lo_reg, got_lo_next;

    logic in_run;
    logic redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= BOOT_HI;
            pc_reg     <= '0;
            vec_hi_reg <= '0;
            ret_hi_reg <= '0;
            ret_lo_reg <= '0;
            got_hi_reg <= 1'b0;
            got_lo_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            vec_hi_reg <= vec_hi_next;
            ret_hi_reg <= ret_hi_next;
            ret_lo_reg <= ret_lo_next;
            got_hi_reg <= got_hi_next;
            got_lo_reg <= got_lo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        vec_hi_next = vec_hi_reg;
        ret_hi_next = ret_hi_reg;
        ret_lo_next = ret_lo_reg;
        got_hi_next = got_hi_reg;
        got_lo_next = got_lo_reg;
        in_run      = 1'b0;
        redirect    = 1'b0;

        case (state_reg)
            BOOT_HI: begin
                vec_hi_next = imem_data;
                pc_next     = pc_reg + PC_W'(1);
                state_next  = BOOT_LO;
            end
            BOOT_LO: begin
                pc_next    = {vec_hi_reg, imem_data};
                state_next = RUN;
            end
            RUN: begin
                in_run = 1'b1;
                if (got_hi_reg && got_lo_reg) begin
                    // A completed return load outranks everything, including an interrupt
                    redirect    = 1'b1;
                    pc_next     = {ret_hi_reg, ret_lo_reg};
                    got_hi_next = 1'b0;
                    got_lo_next = 1'b0;
                end else if (pc_sel == PC_SEL_INT) begin
                    redirect = 1'b1;
`ifdef FETCH_INT_VECTOR_FROM_MEM_EN
                    pc_next    = PC_W'(IMEM_INT_ADDR);
                    state_next = VEC_HI;
`else
                    pc_next = INT_VECTOR;
`endif
                end else if (pc_sel == PC_SEL_TGT) begin
                    redirect = 1'b1;
                    pc_next  = target_in;
                end else if (fetch_pc_enable) begin
                    pc_next = pc_reg + PC_W'(1);
                end

                if (pop_pc2) begin
                    ret_hi_next = stack_data;
                    got_hi_next = 1'b1;
                end
                if (pop_pc1) begin
                    ret_lo_next = stack_data;
                    got_lo_next = 1'b1;
                end
            end
`ifdef FETCH_INT_VECTOR_FROM_MEM_EN
            VEC_HI: begin
                vec_hi_next = imem_data;
                pc_next     = pc_reg + PC_W'(1);
                state_next  = VEC_LO;
            end
            VEC_LO: begin
                pc_next    = {vec_hi_reg, imem_data};
                state_next = RUN;
            end
`endif
            default: begin
                state_next = BOOT_HI;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign boot_busy = (state_reg != RUN);

    // Outside RUN the register only ever takes bubbles; controls are ignored
    ifid_reg #(
        .INSTR_W(INSTR_W),
        .PC_W   (PC_W)
    ) u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (in_run & flush_fetch),
        .freeze     (in_run & freeze_cu),
        .bubble     (~in_run | redirect | ~fetch_pc_enable),
        .fetch_instr(imem_data),
        .fetch_pc   (pc_reg + PC_W'(1)),
        .instr      (ifid_instr),
        .pc         (ifid_pc),
        .valid      (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps then random traffic against a cycle model.
module tb_fetch_stage;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [1:0]         pc_sel;
    logic [PC_W-1:0]    target_in;
    logic               fetch_pc_enable;
    logic               freeze_cu;
    logic               flush_fetch;
    logic               pop_pc1;
    logic               pop_pc2;
    logic [INSTR_W-1:0] stack_data;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc;
    logic               ifid_valid;
    logic               boot_busy;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .pc_sel         (pc_sel),
        .target_in      (target_in),
        .fetch_pc_enable(fetch_pc_enable),
        .freeze_cu      (freeze_cu),
        .flush_fetch    (flush_fetch),
        .pop_pc1        (pop_pc1),
        .pop_pc2        (pop_pc2),
        .stack_data     (stack_data),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_valid     (ifid_valid),
        .boot_busy      (boot_busy)
    );

    always #5 clk = ~clk;

    // Low four words are the boot and interrupt vectors; everything else is a hash of the address
    logic [15:0] vec_words [4];

    function automatic logic [15:0] mem_hash(input logic [31:0] a);
        return a[15:0] ^ {a[7:0], a[15:8]} ^ a[31:16] ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] model_mem(input logic [31:0] a);
        if (a < 32'd4) return vec_words[a[1:0]];
        return mem_hash(a);
    endfunction

    always_comb begin
        if (imem_addr < 32'd4) imem_data = vec_words[imem_addr[1:0]];
        else                   imem_data = mem_hash(imem_addr);
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: boot/vector fetch is a countdown, the rest is the redirect priority list
    logic [31:0] m_pc;
    int          m_boot_left;
    logic [15:0] m_hi, m_rhi, m_rlo;
    bit          m_ghi, m_glo;
    logic [15:0] m_instr;
    logic [31:0] m_ipc;
    bit          m_valid;

    task automatic model_reset();
        m_pc = 0; m_boot_left = 2; m_hi = 0; m_rhi = 0; m_rlo = 0;
        m_ghi = 0; m_glo = 0; m_instr = 0; m_ipc = 0; m_valid = 0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        bit          rl, redir;
        w = model_mem(m_pc);
        if (m_boot_left > 0) begin
            if (m_boot_left == 2) begin
                m_hi = w;
                m_pc = m_pc + 1;
            end else begin
                m_pc = {m_hi, w};
            end
            m_boot_left--;
            m_instr = 0;
            m_valid = 0;
        end else begin
            rl    = m_ghi && m_glo;
            redir = rl || pc_sel == 2'b10 || pc_sel == 2'b11;
            if (fetch_pc_enable == 0 || redir || flush_fetch || freeze_cu) begin
                if (flush_fetch) begin
                    m_instr = 0; m_valid = 0;
                end else if (!freeze_cu) begin
                    m_instr = 0; m_valid = 0;
                end
            end else begin
                m_instr = w; m_ipc = m_pc + 1; m_valid = 1;
            end
            if (rl) begin
                m_pc = {m_rhi, m_rlo};
                m_ghi = 0; m_glo = 0;
            end else if (pc_sel == 2'b10) begin
`ifdef FETCH_INT_VECTOR_FROM_MEM_EN
                m_pc = 32'd2;
                m_boot_left = 2;
`else
                m_pc = 32'h0000_0002;
`endif
            end else if (pc_sel == 2'b11) begin
                m_pc = target_in;
            end else if (fetch_pc_enable) begin
                m_pc = m_pc + 1;
            end
            if (pop_pc2) begin m_rhi = stack_data; m_ghi = 1; end
            if (pop_pc1) begin m_rlo = stack_data; m_glo = 1; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/pc"},    imem_addr, m_pc);
        chk({tag, "/instr"}, 32'(ifid_instr), 32'(m_instr));
        chk({tag, "/ifpc"},  ifid_pc, m_ipc);
        chk({tag, "/valid"}, 32'(ifid_valid), 32'(m_valid));
        chk({tag, "/busy"},  32'(boot_busy), (m_boot_left > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        pc_sel = 2'b00; target_in = 0; fetch_pc_enable = 1'b1;
        freeze_cu = 0; flush_fetch = 0; pop_pc1 = 0; pop_pc2 = 0; stack_data = 0;
    endtask

    // Called just after an edge; reset is seen immediately, then held across one edge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        vec_words[0] = 16'h0000;
        vec_words[1] = 16'h0020;
        vec_words[2] = 16'h0000;
        vec_words[3] = 16'h0300;
        idle();
        model_reset();

        do_reset("reset");
        chk("reset_busy", 32'(boot_busy), 32'd1);

        tick("boot1");
        tick("boot2");
        chk("boot_pc", imem_addr, 32'h20);
        chk("boot_done", 32'(boot_busy), 32'd0);
        tick("first");
        chk("first_instr", 32'(ifid_instr), 32'(model_mem(32'h20)));
        chk("first_ifpc", ifid_pc, 32'h21);
        chk("first_valid", 32'(ifid_valid), 32'd1);

        repeat (4) tick("seq");
        fetch_pc_enable = 1'b0;
        repeat (3) begin
            tick("stall");
            chk("stall_pc", imem_addr, 32'h25);
            chk("stall_valid", 32'(ifid_valid), 32'd0);
        end
        fetch_pc_enable = 1'b1;
        tick("resume");
        chk("resume_instr", 32'(ifid_instr), 32'(model_mem(32'h25)));
        chk("resume_ifpc", ifid_pc, 32'h26);

        pc_sel = 2'b11; target_in = 32'h100; flush_fetch = 1'b1;
        tick("branch");
        chk("branch_pc", imem_addr, 32'h100);
        chk("branch_valid", 32'(ifid_valid), 32'd0);
        idle();
        tick("branch_tgt");
        chk("branch_instr", 32'(ifid_instr), 32'(model_mem(32'h100)));

        idle(); fetch_pc_enable = 1'b0;
        pop_pc2 = 1'b1; stack_data = 16'h0001;
        tick("ret_pop2");
        pop_pc2 = 1'b0; pop_pc1 = 1'b1; stack_data = 16'h0004;
        tick("ret_pop1");
        pop_pc1 = 1'b0;
        tick("ret_load");
        chk("ret_pc", imem_addr, 32'h0001_0004);
        pc_sel = 2'b11; target_in = 32'h40;
        tick("ret_move");
        pc_sel = 2'b00;
        pop_pc1 = 1'b1; stack_data = 16'h0004;
        tick("ret2_pop1");
        pop_pc1 = 1'b0; pop_pc2 = 1'b1; stack_data = 16'h0001;
        tick("ret2_pop2");
        pop_pc2 = 1'b0;
        tick("ret2_load");
        chk("ret2_pc", imem_addr, 32'h0001_0004);

        idle(); pc_sel = 2'b10;
        tick("int");
        chk("int_pc", imem_addr, 32'h2);
        idle();
`ifdef FETCH_INT_VECTOR_FROM_MEM_EN
        chk("int_busy", 32'(boot_busy), 32'd1);
        tick("vec1");
        chk("vec_busy", 32'(boot_busy), 32'd1);
        tick("vec2");
        chk("vec_pc", imem_addr, 32'h300);
`else
        chk("int_busy", 32'(boot_busy), 32'd0);
`endif

        pc_sel = 2'b11; target_in = 32'hFFFF_FFFF;
        tick("wrap_set");
        idle();
        tick("wrap");
        chk("wrap_pc", imem_addr, 32'h0);

        pop_pc2 = 1'b1; stack_data = 16'h0055;
        tick("rst_pop");
        idle();
        do_reset("midpop_rst");
        tick("reboot1");
        tick("reboot2");
        chk("reboot_pc", imem_addr, 32'h20);
        pop_pc1 = 1'b1; stack_data = 16'h0066;
        tick("stale_pop1");
        idle();
        tick("stale_chk");
        chk("stale_pc", imem_addr, 32'h22);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            pc_sel          = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : 2'($urandom_range(0, 1));
            target_in       = $urandom;
            fetch_pc_enable = ($urandom_range(0, 3) != 0);
            freeze_cu       = ($urandom_range(0, 7) == 0);
            flush_fetch     = ($urandom_range(0, 7) == 0);
            pop_pc1         = ($urandom_range(0, 5) == 0);
            pop_pc2         = ($urandom_range(0, 5) == 0);
            stack_data      = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                idle();
                do_reset("rand_rst");
            end else begin
                tick("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
